// File: rtl/seq_signed_div_pkg.sv
// Shared definitions for the sequential signed/unsigned divider.
//   state_t    : FSM state encoding (IDLE/RUN/FIX/ERR, 2 bits)
//   cnt_width  : width of the step counter for a given operand width
package seq_signed_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Counter must hold W-1; operand width is at least 2, so never below 1 bit.
  function automatic int cnt_width(input int w);
    if (w > 2) begin
      return $clog2(w);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/seq_signed_div_step.sv
// One combinational restoring-division step.
//   part      in  W+1  current partial remainder (always < dvs)
//   bit_in    in  1    next dividend bit, MSB first
//   dvs       in  W+1  divisor magnitude
//   part_next out W+1  partial remainder after this step
//   qbit      out 1    quotient bit produced by this step
module seq_signed_div_step #(
  parameter int W = 6
) (
  input  logic [W:0] part,
  input  logic       bit_in,
  input  logic [W:0] dvs,
  output logic [W:0] part_next,
  output logic       qbit
);

  logic [W+1:0] shifted_s;

  // Shift in the next dividend bit and trial-subtract; restore on a negative result.
  always_comb begin
    shifted_s = {part, bit_in};
    if (shifted_s >= {1'b0, dvs}) begin
      qbit      = 1'b1;
      part_next = (W+1)'(shifted_s - {1'b0, dvs});
    end else begin
      qbit      = 1'b0;
      part_next = (W+1)'(shifted_s);
    end
  end

endmodule

// File: rtl/seq_signed_div.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Parameters: W (operand width, >= 2), SIGNED (1: two's complement, 0: unsigned).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                request, accepted only when idle
//   dividend, divisor    operands, sampled on the accepting edge
//   busy                 high from the accepting edge until done
//   done                 one-cycle pulse when results are valid
//   quotient, remainder  results (truncated toward zero), held
//   err                  divide-by-zero or signed overflow, valid with done
// Build option: define SEQDIV_SAT_EN to saturate the quotient on signed
// overflow (-2^(W-1) / -1) to +(2^(W-1)-1); otherwise it wraps to -2^(W-1).
module seq_signed_div
  import seq_signed_div_pkg::*;
#(
  parameter int W      = 6,
  parameter bit SIGNED = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         err
);

  localparam int           CW      = cnt_width(W);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_POS = ~MIN_NEG;

`ifdef SEQDIV_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_t          state_r, state_s;
  logic [CW-1:0]   count_r;
  // Dividend magnitude shifts out MSB first while quotient bits shift in.
  logic [W-1:0]    dq_r;
  logic [W:0]      part_r;
  logic [W:0]      dvs_r;
  logic [W-1:0]    dvd_raw_r;
  logic            sgn_n_r, sgn_d_r;
  logic            busy_r, done_r, err_r;
  logic [W-1:0]    quot_r, rem_r;

  logic            accept_s;
  logic            sgn_n_s, sgn_d_s;
  logic [W:0]      dvd_mag_s, dvs_mag_s;
  logic [W:0]      part_next_s;
  logic            qbit_s;
  logic [W:0]      q_fix_s, r_fix_s;
  logic            ovf_s;

  // Sign-extend (or zero-extend when unsigned) to the W+1-bit internal width.
  function automatic logic [W:0] widen(input logic [W-1:0] v);
    if (SIGNED) begin
      return {v[W-1], v};
    end else begin
      return {1'b0, v};
    end
  endfunction

  // Two's-complement negate when requested; W+1 bits so -2^(W-1) negates cleanly.
  function automatic logic [W:0] neg_if(input logic [W:0] v, input logic n);
    if (n) begin
      return (~v) + (W+1)'(1);
    end else begin
      return v;
    end
  endfunction

  seq_signed_div_step #(.W(W)) u_step (
    .part      (part_r),
    .bit_in    (dq_r[W-1]),
    .dvs       (dvs_r),
    .part_next (part_next_s),
    .qbit      (qbit_s)
  );

  // Operand magnitudes and sign bits for the accepting edge.
  always_comb begin
    sgn_n_s   = SIGNED & dividend[W-1];
    sgn_d_s   = SIGNED & divisor[W-1];
    dvd_mag_s = neg_if(widen(dividend), sgn_n_s);
    dvs_mag_s = neg_if(widen(divisor), sgn_d_s);
  end

  // Sign correction of the finished magnitudes and overflow detection.
  always_comb begin
    q_fix_s = neg_if({1'b0, dq_r}, sgn_n_r ^ sgn_d_r);
    r_fix_s = neg_if(part_r, sgn_n_r);
    ovf_s   = SIGNED && (dvd_raw_r == MIN_NEG) && sgn_d_r && (dvs_r == (W+1)'(1));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; a request is only taken while idle.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          if (divisor == {W{1'b0}}) begin
            state_s = ERR;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (count_r == {CW{1'b0}}) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      FIX:     state_s = IDLE;
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand capture and the per-cycle restoring step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r   <= {CW{1'b0}};
      dq_r      <= {W{1'b0}};
      part_r    <= {(W+1){1'b0}};
      dvs_r     <= {(W+1){1'b0}};
      dvd_raw_r <= {W{1'b0}};
      sgn_n_r   <= 1'b0;
      sgn_d_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            count_r   <= CW'(W-1);
            dq_r      <= W'(dvd_mag_s);
            part_r    <= {(W+1){1'b0}};
            dvs_r     <= dvs_mag_s;
            dvd_raw_r <= dividend;
            sgn_n_r   <= sgn_n_s;
            sgn_d_r   <= sgn_d_s;
          end
        end
        RUN: begin
          count_r <= count_r - CW'(1);
          dq_r    <= {dq_r[W-2:0], qbit_s};
          part_r  <= part_next_s;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      quot_r <= {W{1'b0}};
      rem_r  <= {W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            busy_r <= 1'b1;
          end
        end
        FIX: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          err_r  <= ovf_s;
          rem_r  <= W'(r_fix_s);
          if (ovf_s && SAT_EN) begin
            quot_r <= MAX_POS;
          end else begin
            quot_r <= W'(q_fix_s);
          end
        end
        ERR: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          err_r  <= 1'b1;
          quot_r <= {W{1'b0}};
          rem_r  <= dvd_raw_r;
        end
        default: begin
          busy_r <= busy_r;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign quotient  = quot_r;
  assign remainder = rem_r;

endmodule

// File: tb/tb_seq_signed_div.sv
// Self-checking bench for seq_signed_div: three instances
// (W=6 signed, W=6 unsigned, W=16 unsigned), a hand-written vector table,
// corner-case sequences and randomized operands against an arithmetic model.
module tb_seq_signed_div;

`ifdef SEQDIV_SAT_EN
  localparam longint QOVF = 31;
`else
  localparam longint QOVF = -32;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [5:0]  dvd0 = '0, dvs0 = '0, q0, r0;
  logic [5:0]  dvd1 = '0, dvs1 = '0, q1, r1;
  logic [15:0] dvd2 = '0, dvs2 = '0, q2, r2;
  logic        busy0, done0, err0, busy1, done1, err1, busy2, done2, err2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  seq_signed_div #(.W(6), .SIGNED(1'b1)) u_s6 (
    .clk(clk), .rst_n(rst_n), .start(start0), .dividend(dvd0), .divisor(dvs0),
    .busy(busy0), .done(done0), .quotient(q0), .remainder(r0), .err(err0));
  seq_signed_div #(.W(6), .SIGNED(1'b0)) u_u6 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dividend(dvd1), .divisor(dvs1),
    .busy(busy1), .done(done1), .quotient(q1), .remainder(r1), .err(err1));
  seq_signed_div #(.W(16), .SIGNED(1'b0)) u_u16 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dividend(dvd2), .divisor(dvs2),
    .busy(busy2), .done(done2), .quotient(q2), .remainder(r2), .err(err2));

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic sel_done(input int sel);
    case (sel)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic sel_busy(input int sel);
    case (sel)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  // Reference: plain integer division (truncating, remainder follows dividend).
  function automatic void ref_div(input int sel, input longint a, input longint b,
                                  output longint q, output longint r,
                                  output bit e, output int lat);
    int w;
    w = (sel == 2) ? 16 : 6;
    if (b == 0) begin
      q = 0; r = a; e = 1'b1; lat = 1;
    end else if (sel == 0 && a == -(longint'(1) << (w-1)) && b == -1) begin
      q = QOVF; r = 0; e = 1'b1; lat = w + 1;
    end else begin
      q = a / b; r = a % b; e = 1'b0; lat = w + 1;
    end
  endfunction

  // Issue one division (call just after a falling edge) and wait for done.
  task automatic do_div(input int sel, input longint a, input longint b,
                        output longint q, output longint r, output logic e, output int lat);
    bit got;
    case (sel)
      0: begin dvd0 = a[5:0];  dvs0 = b[5:0];  start0 = 1'b1; end
      1: begin dvd1 = a[5:0];  dvs1 = b[5:0];  start1 = 1'b1; end
      default: begin dvd2 = a[15:0]; dvs2 = b[15:0]; start2 = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    chk("busy_after_accept", longint'(sel_busy(sel)), 1);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (sel_done(sel)) got = 1'b1;
    end
    if (!got) begin
      total_cnt++;
      $display("FAIL done_timeout: got no done, expected done within 40 cycles");
    end
    case (sel)
      0: begin q = longint'($signed(q0)); r = longint'($signed(r0)); e = err0; end
      1: begin q = longint'(q1); r = longint'(r1); e = err1; end
      default: begin q = longint'(q2); r = longint'(r2); e = err2; end
    endcase
  endtask

  typedef struct {
    int     sel;
    longint a, b, q, r;
    bit     e;
    int     lat;
  } vec_t;

  initial begin
    vec_t   tbl[12];
    longint q, r, eq, er, a, b;
    logic   e;
    bit     ee;
    int     lat, elat, ndone;

    tbl[0]  = '{0,  13,  4,  3,  1, 1'b0, 7};
    tbl[1]  = '{0, -13,  4, -3, -1, 1'b0, 7};
    tbl[2]  = '{0,  13, -4, -3,  1, 1'b0, 7};
    tbl[3]  = '{0, -13, -4,  3, -1, 1'b0, 7};
    tbl[4]  = '{0,  17,  0,  0, 17, 1'b1, 1};
    tbl[5]  = '{0, -32, -1, QOVF, 0, 1'b1, 7};
    tbl[6]  = '{0, -32,  0,  0, -32, 1'b1, 1};
    tbl[7]  = '{0, -32,  1, -32, 0, 1'b0, 7};
    tbl[8]  = '{0,  31, -32, 0, 31, 1'b0, 7};
    tbl[9]  = '{0,   0,  5,  0,  0, 1'b0, 7};
    tbl[10] = '{1,  63,  5, 12,  3, 1'b0, 7};
    tbl[11] = '{2, 40000, 7, 5714, 2, 1'b0, 17};

    // Reset state
    #8;
    chk("rst_busy", longint'(busy0), 0);
    chk("rst_done", longint'(done0), 0);
    chk("rst_err", longint'(err0), 0);
    chk("rst_q", longint'(q0), 0);
    chk("rst_r", longint'(r0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table (consecutive calls also exercise back-to-back starts)
    foreach (tbl[i]) begin
      do_div(tbl[i].sel, tbl[i].a, tbl[i].b, q, r, e, lat);
      chk($sformatf("tbl%0d_q", i), q, tbl[i].q);
      chk($sformatf("tbl%0d_r", i), r, tbl[i].r);
      chk($sformatf("tbl%0d_err", i), longint'(e), longint'(tbl[i].e));
      chk($sformatf("tbl%0d_lat", i), longint'(lat), longint'(tbl[i].lat));
    end

    // done is a single pulse and busy drops with it
    @(negedge clk);
    chk("done_pulse_width", longint'(done2), 0);
    chk("busy_after_done", longint'(busy2), 0);

    // start pulsed mid-RUN with new operands is ignored
    dvd0 = 6'd13; dvs0 = 6'd4; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    lat = 0; ndone = 0;
    for (int i = 0; i < 40 && ndone == 0; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 3) begin
        dvd0 = 6'h2C; dvs0 = 6'd3; start0 = 1'b1;
      end else begin
        start0 = 1'b0;
      end
      @(negedge clk);
      if (done0) ndone++;
    end
    chk("ignore_lat", longint'(lat), 7);
    chk("ignore_q", longint'($signed(q0)), 3);
    chk("ignore_r", longint'($signed(r0)), 1);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    chk("ignore_no_extra_done", longint'(ndone), 0);

    // Reset mid-RUN aborts without a done pulse
    dvd0 = 6'h33; dvs0 = 6'd4; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs", longint'({busy0, done0, err0, q0, r0}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done0 || busy0) ndone++;
    end
    chk("abort_no_done", longint'(ndone), 0);
    do_div(0, 13, 4, q, r, e, lat);
    chk("after_abort_q", q, 3);
    chk("after_abort_r", r, 1);
    chk("after_abort_lat", longint'(lat), 7);

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 90; i++) begin
      int sel;
      sel = i % 3;
      case (sel)
        0: begin
          a = longint'($urandom_range(0, 63)) - 32;
          b = (i % 15 == 0) ? 0 : longint'($urandom_range(0, 63)) - 32;
        end
        1: begin
          a = longint'($urandom_range(0, 63));
          b = longint'($urandom_range(0, 63));
        end
        default: begin
          a = longint'($urandom_range(0, 65535));
          b = (i % 2 == 0) ? longint'($urandom_range(1, 300)) : longint'($urandom_range(0, 65535));
        end
      endcase
      ref_div(sel, a, b, eq, er, ee, elat);
      do_div(sel, a, b, q, r, e, lat);
      chk($sformatf("rnd%0d_q(%0d/%0d)", i, a, b), q, eq);
      chk($sformatf("rnd%0d_r(%0d/%0d)", i, a, b), r, er);
      chk($sformatf("rnd%0d_err", i), longint'(e), longint'(ee));
      chk($sformatf("rnd%0d_lat", i), longint'(lat), longint'(elat));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
